// File: rtl/aes_ct_serializer.sv
// AES ciphertext serializer: captures 128-bit ciphertext blocks on the rising edge
// of valid_in into a small block FIFO and streams them out MSB-first as bytes over
// a valid/ready handshake. Blocks arriving while the FIFO is full are dropped and
// flagged through a sticky overflow bit.
module aes_ct_serializer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ciphertext0_in,
  input  logic [31:0] ciphertext1_in,
  input  logic [31:0] ciphertext2_in,
  input  logic [31:0] ciphertext3_in,
  input  logic        valid_in,
  output logic [7:0]  byte_out,
  output logic        byte_valid_out,
  input  logic        byte_ready_in,
  output logic        last_out,
  output logic        busy_out,
  output logic        overflow_out,
  input  logic        clr_ovf_in
);

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } state_e;

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  // Block storage; contents are only meaningful where count says so, so no reset.
  logic [127:0] mem_q [DEPTH];

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [3:0]    index_q, index_d;
  logic          valid_d_q;
  logic          ovf_q, ovf_d;

  logic          capture;
  logic          full;
  logic          sending;
  logic          xfer;
  logic          pop;
  logic          push;
  logic          drop;
  logic [127:0]  head_blk;
  logic [127:0]  in_blk;
  logic [7:0]    head_byte;

  assign in_blk  = {ciphertext0_in, ciphertext1_in, ciphertext2_in, ciphertext3_in};
  assign capture = valid_in & ~valid_d_q;
  assign full    = (count_q == FullCount);
  assign sending = (state_q == StSend);
  assign xfer    = sending & byte_ready_in;
  assign pop     = xfer & (index_q == 4'd15);
  // A full FIFO still takes a block when the head entry retires on the same edge.
  assign push    = capture & (~full | pop);
  assign drop    = capture & full & ~pop;

  // Byte index 0 is the most significant byte of ciphertext word 0.
  assign head_blk  = mem_q[rd_ptr_q];
  assign head_byte = head_blk[{~index_q, 3'b000} +: 8];

  // Output decode: everything is derived from registered state so it stays stable
  // while the consumer stalls.
  always_comb begin
    byte_valid_out = sending;
    byte_out       = sending ? head_byte : 8'h00;
    last_out       = sending & (index_q == 4'd15);
    busy_out       = (count_q != '0) | sending;
    overflow_out   = ovf_q;
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  // Sticky overflow: a drop on the same edge as a clear wins.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_in) begin
      ovf_d = 1'b0;
    end
  end

  // Output FSM next-state: walk the 16 bytes of the head entry, then move on to
  // the next entry without a bubble or fall back to idle.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    unique case (state_q)
      StIdle: begin
        index_d = 4'd0;
        if (count_q != '0) begin
          state_d = StSend;
        end
      end
      StSend: begin
        if (xfer) begin
          if (index_q == 4'd15) begin
            index_d = 4'd0;
            if (count_d == '0) begin
              state_d = StIdle;
            end
          end else begin
            index_d = index_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        index_d = 4'd0;
      end
    endcase
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      index_q   <= 4'd0;
      valid_d_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      index_q   <= index_d;
      valid_d_q <= valid_in;
      ovf_q     <= ovf_d;
    end
  end

  // Block storage write; gated by reset so a capture during reset leaves no trace.
  always_ff @(posedge CLK) begin
    if (RST && push) begin
      mem_q[wr_ptr_q] <= in_blk;
    end
  end

endmodule

// File: tb/tb_aes_ct_serializer.sv
// Bench for aes_ct_serializer: a queue-of-blocks reference model checked against
// the DUT every cycle, plus directed scenarios with hand-computed expectations.
module tb_aes_ct_serializer;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] c0, c1, c2, c3;
  logic        vin;
  logic        rdy;
  logic        clr;
  logic [7:0]  byte_out;
  logic        byte_valid_out;
  logic        last_out;
  logic        busy_out;
  logic        overflow_out;

  aes_ct_serializer #(
    .DEPTH(DEPTH),
    .AW   (1)
  ) dut (
    .CLK           (clk),
    .RST           (rst_n),
    .ciphertext0_in(c0),
    .ciphertext1_in(c1),
    .ciphertext2_in(c2),
    .ciphertext3_in(c3),
    .valid_in      (vin),
    .byte_out      (byte_out),
    .byte_valid_out(byte_valid_out),
    .byte_ready_in (rdy),
    .last_out      (last_out),
    .busy_out      (busy_out),
    .overflow_out  (overflow_out),
    .clr_ovf_in    (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: FIFO of whole blocks, the head is being presented when active.
  logic [127:0] mq[$];
  bit           m_active  = 0;
  int           m_idx     = 0;
  bit           m_vprev   = 0;
  bit           m_ovf     = 0;
  bit           m_started = 0;

  // Observed transfers.
  logic [7:0] em[$];
  int         em_t[$];
  int         cyc       = 0;
  bit         saw_valid = 0;
  logic [7:0] saw_byte  = 8'h00;

  logic [7:0] kat [16] = '{8'h29, 8'hc3, 8'h50, 8'h5f, 8'h57, 8'h14, 8'h20, 8'hf6,
                           8'h40, 8'h22, 8'h99, 8'hb3, 8'h1a, 8'h02, 8'hd7, 8'h3a};
  localparam logic [127:0] KatBlk = 128'h29c3505f_571420f6_402299b3_1a02d73a;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_update();
    int old_size;
    bit cap, xfer, pop;
    if (!rst_n) begin
      mq.delete();
      m_active = 0;
      m_idx    = 0;
      m_vprev  = 0;
      m_ovf    = 0;
    end else begin
      old_size = mq.size();
      cap      = vin && !m_vprev;
      xfer     = m_active && rdy;
      pop      = xfer && (m_idx == 15);
      if (xfer) begin
        if (pop) begin
          void'(mq.pop_front());
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end
      if (cap && (old_size < DEPTH || pop)) mq.push_back({c0, c1, c2, c3});
      if (cap && old_size == DEPTH && !pop) m_ovf = 1;
      else if (clr) m_ovf = 0;
      if (m_active) begin
        if (pop) m_active = (mq.size() != 0);
      end else begin
        m_active = (old_size != 0);
      end
      m_vprev = vin;
    end
  endtask

  function automatic logic [7:0] model_byte();
    logic [127:0] blk;
    if (!m_active) return 8'h00;
    blk = mq[0];
    blk = blk >> (8 * (15 - m_idx));
    return blk[7:0];
  endfunction

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (m_started) begin
      chk("byte_valid", 128'(byte_valid_out), 128'(m_active));
      chk("byte_out", 128'(byte_out), 128'(model_byte()));
      chk("last", 128'(last_out), 128'(m_active && m_idx == 15));
      chk("busy", 128'(busy_out), 128'(m_active || mq.size() != 0));
      chk("overflow", 128'(overflow_out), 128'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n && saw_valid && rdy) begin
      em.push_back(saw_byte);
      em_t.push_back(cyc);
    end
    model_update();
    m_started = 1;
    cyc++;
    @(negedge clk);
    saw_valid = byte_valid_out;
    saw_byte  = byte_out;
  endtask

  task automatic set_blk(input logic [127:0] b);
    {c0, c1, c2, c3} = b;
  endtask

  function automatic logic [127:0] packed_blk(input int off);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) r = {r[119:0], em[off + i]};
    return r;
  endfunction

  task automatic clear_em();
    em.delete();
    em_t.delete();
  endtask

  logic [127:0] blk_a, blk_b, blk_c, blk_d;

  initial begin
    rst_n = 1'b0;
    vin   = 1'b0;
    rdy   = 1'b0;
    clr   = 1'b0;
    set_blk('0);
    tick();
    tick();
    chk("rst_byte", 128'(byte_out), 128'h0);
    chk("rst_valid", 128'(byte_valid_out), 128'h0);
    chk("rst_last", 128'(last_out), 128'h0);
    chk("rst_busy", 128'(busy_out), 128'h0);
    chk("rst_ovf", 128'(overflow_out), 128'h0);
    rst_n = 1'b1;
    tick();

    // Single-block capture with the KAT ciphertext.
    set_blk(KatBlk);
    rdy = 1'b1;
    vin = 1'b1;
    tick();
    chk("kat_valid_at_capture", 128'(byte_valid_out), 128'h0);
    vin = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("kat_valid", 128'(byte_valid_out), 128'h1);
      chk("kat_byte", 128'(byte_out), 128'(kat[i]));
      chk("kat_last", 128'(last_out), 128'(i == 15));
      tick();
    end
    chk("kat_idle_valid", 128'(byte_valid_out), 128'h0);
    chk("kat_idle_busy", 128'(busy_out), 128'h0);

    // Backpressure: random ready, bytes must arrive complete and in order.
    clear_em();
    rdy = 1'b0;
    vin = 1'b1;
    tick();
    vin = 1'b0;
    for (int i = 0; i < 300 && em.size() < 16; i++) begin
      rdy = 1'($urandom_range(0, 2) == 0);
      tick();
    end
    rdy = 1'b1;
    tick();
    chk("bp_count", 128'(em.size()), 128'd16);
    if (em.size() >= 16) chk("bp_data", packed_blk(0), KatBlk);

    // Held valid: one capture only.
    clear_em();
    vin = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    vin = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("held_count", 128'(em.size()), 128'd16);
    chk("held_ovf", 128'(overflow_out), 128'h0);

    // Overflow: A, B buffered, C dropped.
    blk_a = {$urandom, $urandom, $urandom, $urandom};
    blk_b = {$urandom, $urandom, $urandom, $urandom};
    blk_c = {$urandom, $urandom, $urandom, $urandom};
    clear_em();
    rdy = 1'b0;
    set_blk(blk_a); vin = 1'b1; tick(); vin = 1'b0; tick();
    set_blk(blk_b); vin = 1'b1; tick(); vin = 1'b0; tick();
    chk("ovf_before_c", 128'(overflow_out), 128'h0);
    set_blk(blk_c); vin = 1'b1; tick();
    chk("ovf_after_c", 128'(overflow_out), 128'h1);
    vin = 1'b0;
    tick();
    rdy = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    chk("ovf_count", 128'(em.size()), 128'd32);
    if (em.size() >= 32) begin
      chk("ovf_blk_a", packed_blk(0), blk_a);
      chk("ovf_blk_b", packed_blk(16), blk_b);
      chk("ovf_no_gap", 128'(em_t[31] - em_t[0]), 128'd31);
    end
    chk("ovf_sticky", 128'(overflow_out), 128'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovf_cleared", 128'(overflow_out), 128'h0);

    // Full FIFO, capture of D coincides with the head's final byte.
    blk_d = {$urandom, $urandom, $urandom, $urandom};
    clear_em();
    rdy = 1'b0;
    set_blk(blk_a); vin = 1'b1; tick(); vin = 1'b0; tick();
    set_blk(blk_b); vin = 1'b1; tick(); vin = 1'b0; tick();
    rdy = 1'b1;
    for (int i = 0; i < 40 && !(m_active && m_idx == 15); i++) tick();
    set_blk(blk_d);
    vin = 1'b1;
    tick();
    vin = 1'b0;
    chk("pop_ovf", 128'(overflow_out), 128'h0);
    for (int i = 0; i < 50; i++) tick();
    chk("pop_count", 128'(em.size()), 128'd48);
    if (em.size() >= 48) begin
      chk("pop_blk_a", packed_blk(0), blk_a);
      chk("pop_blk_b", packed_blk(16), blk_b);
      chk("pop_blk_d", packed_blk(32), blk_d);
    end

    // Mid-stream reset at byte index 7.
    set_blk(KatBlk);
    rdy = 1'b1;
    vin = 1'b1;
    tick();
    vin = 1'b0;
    for (int i = 0; i < 20 && !(m_active && m_idx == 7); i++) tick();
    chk("mid_at_idx7", 128'(byte_out), 128'(kat[7]));
    rst_n = 1'b0;
    tick();
    chk("mid_byte", 128'(byte_out), 128'h0);
    chk("mid_valid", 128'(byte_valid_out), 128'h0);
    chk("mid_last", 128'(last_out), 128'h0);
    chk("mid_busy", 128'(busy_out), 128'h0);
    rst_n = 1'b1;
    clear_em();
    for (int i = 0; i < 20; i++) tick();
    chk("mid_silent", 128'(em.size()), 128'd0);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 2) == 0) vin = ~vin;
      rdy   = 1'($urandom_range(0, 3) != 0);
      clr   = 1'($urandom_range(0, 15) == 0);
      rst_n = 1'($urandom_range(0, 499) != 0);
      set_blk({$urandom, $urandom, $urandom, $urandom});
      tick();
    end
    rst_n = 1'b1;
    vin   = 1'b0;
    rdy   = 1'b1;
    clr   = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    chk("final_busy", 128'(busy_out), 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
